// File: rtl/rfc_pkg.sv
// rfc_pkg: shared widths, port count and FSM state encoding for regfile_ctrl.
package rfc_pkg;
  localparam int NPORT = 2;
  localparam int RF_AW = 3;
  localparam int RF_DW = 8;
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t BYTE0 = 2'd1;
  localparam state_t BYTE1 = 2'd2;
  localparam state_t RESP  = 2'd3;
endpackage

// File: rtl/regfile_ctrl_if.sv
// regfile_ctrl_if: two-requester request/grant/response bus of regfile_ctrl.
interface regfile_ctrl_if;
  import rfc_pkg::*;
  logic [NPORT-1:0]   req_valid;
  logic [NPORT-1:0]   req_wr;
  logic [NPORT-1:0]   req_wide;
  logic [RF_AW-1:0]   req_addr [NPORT];
  logic [2*RF_DW-1:0] req_wdata [NPORT];
  logic [NPORT-1:0]   gnt;
  logic [NPORT-1:0]   rsp_valid;
  logic [2*RF_DW-1:0] rsp_rdata;
  modport master (output req_valid, req_wr, req_wide, req_addr, req_wdata,
                  input gnt, rsp_valid, rsp_rdata);
  modport slave (input req_valid, req_wr, req_wide, req_addr, req_wdata,
                 output gnt, rsp_valid, rsp_rdata);
endinterface

// File: rtl/rfc_rr_arbiter.sv
// rfc_rr_arbiter: 2-way grant; round-robin by default, fixed priority (port 0)
// when RFC_FIXED_PRIO_EN is defined.
module rfc_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
`ifdef RFC_FIXED_PRIO_EN
  assign gnt = en ? {req[1] & ~req[0], req[0]} : 2'b00;
`else
  logic last;
  logic pick1;
  // port 1 wins a tie only when port 0 was granted last
  assign pick1 = req[1] & (~req[0] | ~last);
  assign gnt   = en ? {pick1, req[0] & ~pick1} : 2'b00;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= 1'b1;
    else if (|gnt) last <= gnt[1];
`endif
endmodule

// File: rtl/regfile_ctrl.sv
// regfile_ctrl: arbitrates two requesters and sequences narrow/wide accesses onto
// an 8x8 register file. Arbitration mode selected by RFC_FIXED_PRIO_EN.
module regfile_ctrl
  import rfc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  regfile_ctrl_if.slave    bus,
  output logic             busy,
  output logic [RF_AW-1:0] rf_s_in,
  output logic [RF_AW-1:0] rf_s_out,
  output logic [RF_DW-1:0] rf_d_in,
  output logic             rf_write_en,
  output logic             rf_out_en,
  input  logic [RF_DW-1:0] rf_d_out
);
  state_t             state, nxt;
  logic               owner, wr, wide, sel, acc;
  logic [RF_AW-1:0]   addr, a;
  logic [2*RF_DW-1:0] wdata, rdata;

  rfc_rr_arbiter u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state == IDLE && rst_n),
    .req  (bus.req_valid),
    .gnt  (bus.gnt)
  );

  assign sel = bus.gnt[1];

  always_comb begin
    nxt = state == IDLE  ? (|bus.gnt ? BYTE0 : IDLE) :
          state == BYTE0 ? (wide ? BYTE1 : RESP) :
          state == BYTE1 ? RESP : IDLE;
    acc = state == BYTE0 || state == BYTE1;
    a = state == BYTE1 ? {addr[RF_AW-1:1], 1'b1} :
        wide ? {addr[RF_AW-1:1], 1'b0} : addr;
    rf_write_en = acc & wr;
    rf_out_en   = acc & ~wr;
    rf_s_in  = rf_write_en ? a : '0;
    rf_s_out = rf_out_en ? a : '0;
    rf_d_in  = rf_write_en ? (state == BYTE1 ? wdata[2*RF_DW-1:RF_DW] : wdata[RF_DW-1:0]) : '0;
  end

  assign busy          = state != IDLE;
  assign bus.rsp_valid = state == RESP ? {owner, ~owner} : 2'b00;
  assign bus.rsp_rdata = rdata;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
      wr    <= 1'b0;
      wide  <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      rdata <= '0;
    end else begin
      state <= nxt;
      // capture register is cleared on grant so writes respond with zero
      if (state == IDLE && |bus.gnt) begin
        owner <= sel;
        wr    <= bus.req_wr[sel];
        wide  <= bus.req_wide[sel];
        addr  <= bus.req_addr[sel];
        wdata <= bus.req_wdata[sel];
        rdata <= '0;
      end
      if (rf_out_en && state == BYTE0) rdata[RF_DW-1:0] <= rf_d_out;
      if (rf_out_en && state == BYTE1) rdata[2*RF_DW-1:RF_DW] <= rf_d_out;
    end
endmodule

// File: doc/regfile_ctrl.md
# regfile_ctrl

Sequencer and two-port arbiter in front of the 8 x 8-bit register file. It accepts byte (narrow) or register-pair (wide, 16-bit) read/write requests from two requesters: execute writeback (port 0) and load/store unit (port 1). Each request becomes one or two single-byte register-file accesses. It drives the register file's select, write-enable and output-enable pins, and returns completion and read data to the owning requester.

## Interface
- RF_AW, 3, register-file select width (8 registers)
- RF_DW, 8, register-file data width; wide transfers are 2*RF_DW
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid[k]  in  1 each (k=0,1)  request pending; held stable until granted
- req_wr[k]  in  1  1=write, 0=read
- req_wide[k]  in  1  1=register pair (addr bit0 ignored), 0=single byte
- req_addr[k]  in  RF_AW  register index
- req_wdata[k]  in  2*RF_DW  write data; low byte used when narrow
- gnt[k]  out  1  one-cycle pulse: request accepted
- rsp_valid[k]  out  1  one-cycle completion pulse
- rsp_rdata  out  2*RF_DW  read data, shared and qualified by rsp_valid[k]
- busy  out  1  FSM not IDLE
- rf_s_in, rf_s_out  out  RF_AW  register-file write/read select
- rf_d_in  out  RF_DW  register-file write data
- rf_write_en, rf_out_en  out  1  register-file strobes
- rf_d_out  in  RF_DW  register-file read data; high-Z unless rf_out_en

## Operation
- FSM states: IDLE, BYTE0, BYTE1, RESP.
- IDLE
  - If any req_valid is high, arbitrate and pulse gnt[winner].
  - Latch the winner's wr/wide/addr/wdata and owner index, then go to BYTE0.
- Arbitration is round-robin between the two ports.
  - The last-granted pointer resets to 1, so port 0 wins the first tie.
  - A lone requester is always granted.
- BYTE0
  - Address is addr with bit0 forced to 0 when wide, else addr.
  - Write: rf_write_en=1, rf_d_in=wdata[7:0].
  - Read: rf_out_en=1, and rf_d_out is captured into rdata[7:0].
  - Next state is BYTE1 if wide, else RESP.
- BYTE1 (wide only)
  - Address is addr|1.
  - Write: wdata[15:8]. Read: captures rdata[15:8].
  - Next state is RESP.
- RESP
  - Pulse rsp_valid[owner]; rsp_rdata is driven from the capture register.
  - Writes return 0. Narrow reads return {8'h00, byte}.
  - Next state is IDLE.
- rf_write_en and rf_out_en are never both 1. Both are 0 in IDLE and RESP.
- rf_s_in, rf_s_out and rf_d_in are 0 whenever their strobe is 0.
- rf_d_out is sampled only when rf_out_en=1.

## Timing
- Grant at cycle T. Narrow: access at T+1, rsp_valid at T+2. Wide: accesses at T+1 and T+2, rsp_valid at T+3.
- Writes land in the register file on the rising edge that ends each BYTE cycle.
- Next grant is possible at the cycle after RESP. Sustained throughput is one narrow op per 3 cycles, or one wide op per 4.
- A request arriving while busy waits; it is evaluated in the next IDLE cycle.
- Reset mid-operation
  - The FSM returns to IDLE with no rsp_valid.
  - A byte already written in BYTE0 remains written; there is no rollback.
- Reset values: gnt=0, rsp_valid=0, rsp_rdata=0, busy=0, all rf_* outputs 0, capture register 0.

## Configuration
- RFC_FIXED_PRIO_EN defined: fixed priority; port 0 always wins a tie, and the last-granted pointer is removed.
- Undefined: round-robin as above.

## Structure
- Package rfc_pkg holds:
  - the state enum (IDLE, BYTE0, BYTE1, RESP)
  - the port-count constant (2)
  - the width constants RF_AW and RF_DW
- Sub-module rfc_rr_arbiter holds the 2-way grant logic and the pointer. The RFC_FIXED_PRIO_EN switch is contained there.

## Test plan
- Port 0 narrow write of 8'hA5 to addr 3 -> gnt[0] at T, rf_write_en with rf_s_in=3 at T+1, rsp_valid[0] at T+2; a following narrow read of addr 3 returns 16'h00A5.
- Port 1 wide write of 16'h1234 to addr 5 -> r4=8'h34, r5=8'h12; a wide read of addr 4 returns 16'h1234 at T+3.
- Both ports valid every cycle, 4 ops each -> grants alternate 0,1,0,1…, with no rf_write_en/rf_out_en overlap.
  - With RFC_FIXED_PRIO_EN: all port-0 grants occur before any port-1 grant.
- rst_n low during BYTE1 of a wide write of 16'hBEEF to pair 6 -> r6=8'hEF, r7 unchanged, no rsp_valid, busy=0 immediately.
- Request arrives while busy -> no gnt until the IDLE cycle after RESP; outputs hold reset values during and after reset.
